// File: rtl/vid_pattern_src_st.sv
// Avalon-ST test pattern source for the clocked-video ITC input.
// Each frame is one VIP control packet (width/height/progressive) followed by
// one video packet of H_ACTIVE*V_ACTIVE pixels, one {R,G,B} pixel per beat.
// All outputs are registered. The next beat is loaded on a transfer, so
// data/sop/eop are held for as long as the sink stalls.
module vid_pattern_src_st #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int CHK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic [23:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [15:0] frame_count
);

    // Frame geometry as 16-bit values, plus the last-pixel coordinates.
    localparam logic [15:0] W16  = 16'(H_ACTIVE);
    localparam logic [15:0] H16  = 16'(V_ACTIVE);
    localparam logic [15:0] W_M1 = 16'(H_ACTIVE - 1);
    localparam logic [15:0] H_M1 = 16'(V_ACTIVE - 1);

    // Incremental bar tracking. bar = floor(8*x/W) is kept as a quotient and
    // a remainder acc = (8*x) mod W. Each step in x adds 8 to 8*x, which is
    // BAR_Q whole bars plus BAR_R remainder, with at most one carry. Both
    // constants are resolved at elaboration, so no divider is built.
    localparam int          BAR_Q   = 8 / H_ACTIVE;
    localparam int          BAR_R   = 8 % H_ACTIVE;
    localparam logic [2:0]  BAR_Q3  = 3'(BAR_Q);
    localparam logic [16:0] BAR_R17 = 17'(BAR_R);
    localparam logic [16:0] W17     = 17'(H_ACTIVE);

    // Control packet payload words (VIP layout, 4-bit nibble per symbol).
    localparam logic [23:0] CTL_HDR = 24'h00000F;
    localparam logic [23:0] CTL_D0  = {4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]};
    localparam logic [23:0] CTL_D1  = {4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
    localparam logic [23:0] CTL_D2  = {4'h0, 4'h0, 4'h0, H16[3:0], 4'h0, H16[7:4]};
    localparam logic [23:0] VID_HDR = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_C_HDR = 3'd1,
        ST_C_D0  = 3'd2,
        ST_C_D1  = 3'd3,
        ST_C_D2  = 3'd4,
        ST_V_HDR = 3'd5,
        ST_PIX   = 3'd6
    } state_t;

    state_t      state_r;
    logic [1:0]  pat_r;
    logic [23:0] solid_r;
    logic [15:0] x_r;
    logic [15:0] y_r;
    logic [2:0]  bar_r;
    logic [16:0] acc_r;

    logic        xfer_s;
    logic        x_last_s;
    logic        y_last_s;
    logic [16:0] acc_sum_s;
    logic [15:0] nx_s;
    logic [15:0] ny_s;
    logic [2:0]  nbar_s;
    logic [16:0] nacc_s;
    logic [23:0] pix_next_s;
    logic [23:0] pix_first_s;

    // Colour of one of the eight standard bars, white down to black.
    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        logic [23:0] c;
        case (bar)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Pixel colour for the selected pattern at coordinate (px, py).
    function automatic logic [23:0] pixel_colour(
        input logic [1:0]  pat,
        input logic [23:0] solid,
        input logic [15:0] px,
        input logic [15:0] py,
        input logic [2:0]  bar
    );
        logic [23:0] c;
        case (pat)
            2'd0:    c = bar_colour(bar);
            2'd1:    c = {px[7:0], px[7:0], px[7:0]};
            2'd2:    c = (px[CHK_LOG2] ^ py[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            2'd3:    c = solid;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Next raster position, next bar index and the colour of the next pixel.
    always_comb begin
        xfer_s    = dout_valid & dout_ready;
        x_last_s  = (x_r == W_M1);
        y_last_s  = (y_r == H_M1);
        acc_sum_s = acc_r + BAR_R17;
        nx_s      = 16'd0;
        ny_s      = y_r;
        nbar_s    = 3'd0;
        nacc_s    = 17'd0;
        if (x_last_s) begin
            nx_s   = 16'd0;
            ny_s   = y_r + 16'd1;
            nbar_s = 3'd0;
            nacc_s = 17'd0;
        end else begin
            nx_s = x_r + 16'd1;
            ny_s = y_r;
            if (acc_sum_s >= W17) begin
                nacc_s = acc_sum_s - W17;
                nbar_s = bar_r + BAR_Q3 + 3'd1;
            end else begin
                nacc_s = acc_sum_s;
                nbar_s = bar_r + BAR_Q3;
            end
        end
        pix_next_s  = pixel_colour(pat_r, solid_r, nx_s, ny_s, nbar_s);
        pix_first_s = pixel_colour(pat_r, solid_r, 16'd0, 16'd0, 3'd0);
    end

    // Packet sequencer: state, raster counters and registered beat outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            pat_r       <= 2'd0;
            solid_r     <= 24'd0;
            x_r         <= 16'd0;
            y_r         <= 16'd0;
            bar_r       <= 3'd0;
            acc_r       <= 17'd0;
            dout_data   <= 24'd0;
            dout_valid  <= 1'b0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        pat_r      <= pattern_sel;
                        solid_r    <= solid_rgb;
                        state_r    <= ST_C_HDR;
                        dout_data  <= CTL_HDR;
                        dout_valid <= 1'b1;
                        dout_sop   <= 1'b1;
                        dout_eop   <= 1'b0;
                    end else begin
                        dout_valid <= 1'b0;
                        dout_sop   <= 1'b0;
                        dout_eop   <= 1'b0;
                    end
                end
                ST_C_HDR: begin
                    if (xfer_s) begin
                        state_r   <= ST_C_D0;
                        dout_data <= CTL_D0;
                        dout_sop  <= 1'b0;
                    end
                end
                ST_C_D0: begin
                    if (xfer_s) begin
                        state_r   <= ST_C_D1;
                        dout_data <= CTL_D1;
                    end
                end
                ST_C_D1: begin
                    if (xfer_s) begin
                        state_r   <= ST_C_D2;
                        dout_data <= CTL_D2;
                        dout_eop  <= 1'b1;
                    end
                end
                ST_C_D2: begin
                    if (xfer_s) begin
                        state_r   <= ST_V_HDR;
                        dout_data <= VID_HDR;
                        dout_sop  <= 1'b1;
                        dout_eop  <= 1'b0;
                    end
                end
                ST_V_HDR: begin
                    if (xfer_s) begin
                        state_r   <= ST_PIX;
                        x_r       <= 16'd0;
                        y_r       <= 16'd0;
                        bar_r     <= 3'd0;
                        acc_r     <= 17'd0;
                        dout_data <= pix_first_s;
                        dout_sop  <= 1'b0;
                        // A 1x1 frame: the first pixel is also the last.
                        dout_eop  <= (W_M1 == 16'd0) && (H_M1 == 16'd0);
                    end
                end
                ST_PIX: begin
                    if (xfer_s) begin
                        if (x_last_s && y_last_s) begin
                            state_r     <= ST_IDLE;
                            x_r         <= 16'd0;
                            y_r         <= 16'd0;
                            bar_r       <= 3'd0;
                            acc_r       <= 17'd0;
                            dout_data   <= 24'd0;
                            dout_valid  <= 1'b0;
                            dout_eop    <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            x_r       <= nx_s;
                            y_r       <= ny_s;
                            bar_r     <= nbar_s;
                            acc_r     <= nacc_s;
                            dout_data <= pix_next_s;
                            dout_eop  <= (nx_s == W_M1) && (ny_s == H_M1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dout_valid <= 1'b0;
                    dout_sop   <= 1'b0;
                    dout_eop   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vid_pattern_src_st.sv
// Directed bench for vid_pattern_src_st on a small 6x3 raster.
`timescale 1ns/1ps
module tb_vid_pattern_src_st;

    localparam int HA = 6;
    localparam int VA = 3;
    localparam int NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'd0;
    logic [23:0] dout_data;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_sop;
    logic        dout_eop;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;
    bit rand_ready = 1'b0;
    bit held_v = 1'b0;
    logic [25:0] held_beat;
    logic [23:0] bars_tab [HA];
    logic [23:0] bd;
    logic bs, be;

    vid_pattern_src_st #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CHK_LOG2(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for the next transferred beat; checks stability across stalls.
    task automatic take_beat(output logic [23:0] d, output logic s, output logic e);
        bit got;
        got = 1'b0;
        d = 24'd0; s = 1'b0; e = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (held_v) begin
                check("stall_valid", {31'd0, dout_valid}, 32'd1);
                check("stall_hold", {6'd0, dout_sop, dout_eop, dout_data}, {6'd0, held_beat});
                held_v = 1'b0;
            end
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dout_valid && dout_ready) begin
                d = dout_data; s = dout_sop; e = dout_eop; got = 1'b1;
            end else if (dout_valid) begin
                held_v = 1'b1;
                held_beat = {dout_sop, dout_eop, dout_data};
            end
        end
        check("beat_timeout", {31'd0, got}, 32'd1);
    endtask

    // Control packet for W=6, H=3, then the video packet header.
    task automatic expect_headers(input string tag);
        take_beat(bd, bs, be); check({tag, "_c_hdr"}, {bs, be, 6'd0, bd}, 32'h8000000F);
        take_beat(bd, bs, be); check({tag, "_c_d0"},  {bs, be, 6'd0, bd}, 32'h00000000);
        take_beat(bd, bs, be); check({tag, "_c_d1"},  {bs, be, 6'd0, bd}, 32'h00000006);
        take_beat(bd, bs, be); check({tag, "_c_d2"},  {bs, be, 6'd0, bd}, 32'h40000300);
        take_beat(bd, bs, be); check({tag, "_v_hdr"}, {bs, be, 6'd0, bd}, 32'h80000000);
    endtask

    // Pixels first..last of a frame drawn with pattern pat.
    task automatic expect_pixels(input string tag, input int pat, input logic [23:0] solid,
                                 input int first, input int last);
        logic [23:0] exp;
        int x, y;
        for (int i = first; i <= last; i++) begin
            x = i % HA;
            y = i / HA;
            case (pat)
                0:       exp = bars_tab[x];
                1:       exp = {3{8'(x)}};
                2:       exp = ((((x >> 1) ^ (y >> 1)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
                default: exp = solid;
            endcase
            take_beat(bd, bs, be);
            check($sformatf("%s_pix%0d", tag, i), {bs, be, 6'd0, bd},
                  {1'b0, (i == NPIX - 1), 6'd0, exp});
        end
    endtask

    // Gap after a frame: IDLE for one cycle with the frame counted.
    task automatic expect_gap(input string tag, input logic [15:0] fc);
        @(negedge clk);
        check({tag, "_gap_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_frame_count"}, {16'd0, frame_count}, {16'd0, fc});
    endtask

    initial begin
        bars_tab[0] = 24'hFFFFFF;
        bars_tab[1] = 24'hFFFF00;
        bars_tab[2] = 24'h00FFFF;
        bars_tab[3] = 24'hFF00FF;
        bars_tab[4] = 24'hFF0000;
        bars_tab[5] = 24'h0000FF;

        // Reset state.
        #12;
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_sop_eop", {30'd0, dout_sop, dout_eop}, 32'd0);
        check("rst_data", {8'd0, dout_data}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_valid", {31'd0, dout_valid}, 32'd0);

        // Frame 1: colour bars, ready held high; checker requested mid-frame.
        pattern_sel = 2'd0;
        enable = 1'b1;
        dout_ready = 1'b1;
        expect_headers("f1");
        expect_pixels("f1", 0, 24'd0, 0, 5);
        pattern_sel = 2'd2;
        expect_pixels("f1", 0, 24'd0, 6, NPIX - 1);
        expect_gap("f1", 16'd1);

        // Frame 2: checker with random stalls; solid requested mid-frame.
        rand_ready = 1'b1;
        expect_headers("f2");
        expect_pixels("f2", 2, 24'd0, 0, 4);
        pattern_sel = 2'd3;
        solid_rgb = 24'h123456;
        expect_pixels("f2", 2, 24'd0, 5, NPIX - 1);
        rand_ready = 1'b0;
        expect_gap("f2", 16'd2);

        // Frame 3: solid colour, enable dropped mid-frame; frame still completes.
        expect_headers("f3");
        expect_pixels("f3", 3, 24'h123456, 0, 3);
        enable = 1'b0;
        solid_rgb = 24'hABCDEF;
        expect_pixels("f3", 3, 24'h123456, 4, NPIX - 1);
        expect_gap("f3", 16'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stopped_valid", {31'd0, dout_valid}, 32'd0);
        end

        // Frame 4: ramp across the line, full frame.
        pattern_sel = 2'd1;
        enable = 1'b1;
        expect_headers("f4");
        expect_pixels("f4", 1, 24'd0, 0, NPIX - 1);
        expect_gap("f4", 16'd4);

        // Frame 5: reset pulsed mid-packet, then restart from the control header.
        take_beat(bd, bs, be); check("f5_c_hdr", {bs, be, 6'd0, bd}, 32'h8000000F);
        take_beat(bd, bs, be); check("f5_c_d0",  {bs, be, 6'd0, bd}, 32'h00000000);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, dout_valid}, 32'd0);
        check("async_rst_beat", {6'd0, dout_sop, dout_eop, dout_data}, 32'd0);
        check("async_rst_frame_count", {16'd0, frame_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_headers("f6");
        expect_pixels("f6", 1, 24'd0, 0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
